// File: rtl/fibonacci_gen_if.sv
// fibonacci_gen_if
// Purpose : groups the Fibonacci generator's control, seed and output
//           handshake signals so the generator and its consumer share one
//           bundle.
// Signals : f_en      advance enable (consumer -> generator)
//           f_load    seed load strobe
//           f_seed_a  first seed term, WIDTH bits
//           f_seed_b  second seed term, WIDTH bits
//           f_ready   consumer accepts f_out
//           f_valid   f_out holds a term (generator -> consumer)
//           f_out     current term, WIDTH bits
//           f_last    f_out is the last term representable in WIDTH bits
//           f_index   index of the term on f_out, IDX_W bits
//                     (only when FIBO_INDEX_EN is defined)
// Modports: master = generator side, slave = consumer side.
interface fibonacci_gen_if #(
   parameter int WIDTH = 16,
   parameter int IDX_W = 6
);

   logic             f_en;
   logic             f_load;
   logic [WIDTH-1:0] f_seed_a;
   logic [WIDTH-1:0] f_seed_b;
   logic             f_ready;
   logic             f_valid;
   logic [WIDTH-1:0] f_out;
   logic             f_last;
`ifdef FIBO_INDEX_EN
   logic [IDX_W-1:0] f_index;
`endif

   modport master (
      input  f_en, f_load, f_seed_a, f_seed_b, f_ready,
`ifdef FIBO_INDEX_EN
      output f_index,
`endif
      output f_valid, f_out, f_last
   );

   modport slave (
      output f_en, f_load, f_seed_a, f_seed_b, f_ready,
`ifdef FIBO_INDEX_EN
      input  f_index,
`endif
      input  f_valid, f_out, f_last
   );

endinterface

// File: rtl/fibonacci_gen.sv
// fibonacci_gen
// Purpose : produces a Fibonacci-style sequence from two loadable seeds,
//           presenting one term per advance through a valid/ready output.
//           When the following term would not fit in WIDTH bits the current
//           term is flagged f_last and the sequence restarts from the seeds.
// Ports   : clock  single clock, all state on the rising edge
//           reset  asynchronous, active-high reset
//           fib    fibonacci_gen_if.master (f_en, f_load, f_seed_a,
//                  f_seed_b, f_ready in; f_valid, f_out, f_last out)
// Options : define FIBO_INDEX_EN to add the f_index output and its counter.
module fibonacci_gen #(
   parameter int WIDTH = 16,
   parameter int IDX_W = 6
) (
   input  logic           clock,
   input  logic           reset,
   fibonacci_gen_if.master fib
);

   logic [WIDTH-1:0] cur;
   logic [WIDTH-1:0] nxt;
   logic             nxt_ovf;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH:0]   sum;
   logic             slot_free;
   logic             advance;
   logic             transfer;

   // The output slot can take a new term when it is empty or being drained
   // this cycle. A load always wins over an advance, so the generator only
   // moves when no load is requested. The sum is one bit wider so its top
   // bit tells whether the upcoming term still fits.
   always_comb begin
      slot_free = !fib.f_valid | fib.f_ready;
      advance   = fib.f_en & slot_free & !fib.f_load;
      transfer  = fib.f_valid & fib.f_ready;
      sum       = {1'b0, cur} + {1'b0, nxt};
   end

   // Generator and output register. nxt_ovf marks that nxt could not hold
   // the true next term, so the term in cur is the last valid one; when it
   // is presented the generator reloads the seeds instead of adding. A load
   // that coincides with a transfer simply lets the consumer take the term
   // and then empties the slot, so nothing is repeated.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur         <= '0;
         nxt         <= WIDTH'(1);
         nxt_ovf     <= 1'b0;
         sa          <= '0;
         sb          <= WIDTH'(1);
         fib.f_valid <= 1'b0;
         fib.f_out   <= '0;
         fib.f_last  <= 1'b0;
      end else if (fib.f_load) begin
         sa          <= fib.f_seed_a;
         sb          <= fib.f_seed_b;
         cur         <= fib.f_seed_a;
         nxt         <= fib.f_seed_b;
         nxt_ovf     <= 1'b0;
         fib.f_valid <= 1'b0;
      end else if (advance) begin
         fib.f_out   <= cur;
         fib.f_last  <= nxt_ovf;
         fib.f_valid <= 1'b1;
         if (nxt_ovf) begin
            cur     <= sa;
            nxt     <= sb;
            nxt_ovf <= 1'b0;
         end else begin
            cur     <= nxt;
            nxt     <= sum[WIDTH-1:0];
            nxt_ovf <= sum[WIDTH];
         end
      end else if (transfer) begin
         fib.f_valid <= 1'b0;
      end
   end

`ifdef FIBO_INDEX_EN
   logic [IDX_W-1:0] idx_cnt;

   // Term index. Each advance presents the count alongside the term and then
   // moves on; presenting the last term restarts the count with the seeds.
   // Ordinary overflow wraps naturally modulo 2^IDX_W.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         idx_cnt     <= '0;
         fib.f_index <= '0;
      end else if (fib.f_load) begin
         idx_cnt     <= '0;
      end else if (advance) begin
         fib.f_index <= idx_cnt;
         if (nxt_ovf) begin
            idx_cnt <= '0;
         end else begin
            idx_cnt <= idx_cnt + IDX_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_fibonacci_gen.sv
// tb_fibonacci_gen
// Purpose : directed, self-checking bench for fibonacci_gen. A 16-bit and an
//           8-bit instance share clock and reset; expected terms come from
//           hand-written values and a small integer model of the sequence.
// Options : index checks are included when FIBO_INDEX_EN is defined.
module tb_fibonacci_gen;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int checkCount = 0;
   int errorCount = 0;

   int mA;
   int mB;
   int mSA;
   int mSB;
   int mIdx;

   int lucasHead [6] = '{2, 1, 3, 4, 7, 11};

   fibonacci_gen_if #(.WIDTH(16), .IDX_W(6)) f16 ();
   fibonacci_gen_if #(.WIDTH(8),  .IDX_W(6)) f8 ();

   fibonacci_gen #(.WIDTH(16), .IDX_W(6)) dut16 (
      .clock (clock),
      .reset (reset),
      .fib   (f16.master)
   );

   fibonacci_gen #(.WIDTH(8), .IDX_W(6)) dut8 (
      .clock (clock),
      .reset (reset),
      .fib   (f8.master)
   );

   // Free-running 10 ns clock.
   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports a mismatch.
   task automatic checkOutput(input string tag, input int observed, input int expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int idx16();
`ifdef FIBO_INDEX_EN
      return int'(f16.f_index);
`else
      return 0;
`endif
   endfunction

   function automatic int idx8();
`ifdef FIBO_INDEX_EN
      return int'(f8.f_index);
`else
      return 0;
`endif
   endfunction

   // Restart the reference sequence from a pair of seeds.
   task automatic modelReset(input int a, input int b);
      mSA  = a;
      mSB  = b;
      mA   = a;
      mB   = b;
      mIdx = 0;
   endtask

   // Compare one presented term against the reference, then step the
   // reference. A term is the last one when its successor exceeds maxv.
   task automatic checkTerm(input string tag, input logic v, input int o,
                            input logic l, input int idx, input int maxv);
      int  t;
      bit  expLast;
      expLast = (mB > maxv);
      checkOutput({tag, "_valid"}, int'(v), 1);
      checkOutput({tag, "_out"}, o, mA);
      checkOutput({tag, "_last"}, int'(l), int'(expLast));
`ifdef FIBO_INDEX_EN
      checkOutput({tag, "_index"}, idx, mIdx);
`else
      if (idx != 0) checkOutput({tag, "_noindex"}, idx, 0);
`endif
      if (expLast) begin
         mA   = mSA;
         mB   = mSB;
         mIdx = 0;
      end else begin
         t    = mA + mB;
         mA   = mB;
         mB   = t;
         mIdx = (mIdx + 1) % 64;
      end
   endtask

   // Drive the 16-bit instance for one clock and settle just past the edge.
   task automatic applyStimulus(input logic en, input logic load, input logic ready);
      f16.f_en    = en;
      f16.f_load  = load;
      f16.f_ready = ready;
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      f16.f_en   = 1'b0;
      f16.f_load = 1'b0;
      reset      = 1'b1;
      @(posedge clock);
      #1;
      reset      = 1'b0;
   endtask

   initial begin
      f16.f_en     = 1'b0;
      f16.f_load   = 1'b0;
      f16.f_ready  = 1'b0;
      f16.f_seed_a = '0;
      f16.f_seed_b = '0;
      f8.f_en      = 1'b0;
      f8.f_load    = 1'b0;
      f8.f_ready   = 1'b0;
      f8.f_seed_a  = '0;
      f8.f_seed_b  = '0;

      #2;
      checkOutput("rst_valid", int'(f16.f_valid), 0);
      checkOutput("rst_out", int'(f16.f_out), 0);
      checkOutput("rst_last", int'(f16.f_last), 0);
      checkOutput("rst_index", idx16(), 0);
      checkOutput("rst8_valid", int'(f8.f_valid), 0);
      @(posedge clock);
      #1;
      reset = 1'b0;

      $display("[TB] basic sequence 0,1,1,2,3,5,8");
      modelReset(0, 1);
      f16.f_en = 1'b1;
      f16.f_ready = 1'b1;
      checkOutput("latency_pre_valid", int'(f16.f_valid), 0);
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         checkTerm("basic", f16.f_valid, int'(f16.f_out), f16.f_last, idx16(), 65535);
      end
      checkOutput("basic_seventh", int'(f16.f_out), 8);

      $display("[TB] transfer without advance empties the slot");
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("drain_valid", int'(f16.f_valid), 0);
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("idle_valid", int'(f16.f_valid), 0);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkTerm("resume", f16.f_valid, int'(f16.f_out), f16.f_last, idx16(), 65535);
      checkOutput("resume_13", int'(f16.f_out), 13);

      $display("[TB] backpressure stall at 5");
      doReset();
      modelReset(0, 1);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         checkTerm("prestall", f16.f_valid, int'(f16.f_out), f16.f_last, idx16(), 65535);
      end
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b0);
         checkOutput("stall_valid", int'(f16.f_valid), 1);
         checkOutput("stall_out", int'(f16.f_out), 5);
      end
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkTerm("poststall", f16.f_valid, int'(f16.f_out), f16.f_last, idx16(), 65535);
      checkOutput("poststall_8", int'(f16.f_out), 8);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkTerm("poststall", f16.f_valid, int'(f16.f_out), f16.f_last, idx16(), 65535);
      checkOutput("poststall_13", int'(f16.f_out), 13);

      $display("[TB] reset pulse during a stall at 13");
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("stall13_out", int'(f16.f_out), 13);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("async_rst_valid", int'(f16.f_valid), 0);
      checkOutput("async_rst_out", int'(f16.f_out), 0);
      checkOutput("async_rst_last", int'(f16.f_last), 0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      modelReset(0, 1);
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         checkTerm("restart", f16.f_valid, int'(f16.f_out), f16.f_last, idx16(), 65535);
      end

      $display("[TB] full 16-bit run to 46368 and wrap");
      doReset();
      modelReset(0, 1);
      for (int i = 0; i < 25; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         checkTerm("run16", f16.f_valid, int'(f16.f_out), f16.f_last, idx16(), 65535);
      end
      checkOutput("top16_out", int'(f16.f_out), 46368);
      checkOutput("top16_last", int'(f16.f_last), 1);
`ifdef FIBO_INDEX_EN
      checkOutput("top16_index", idx16(), 24);
`endif
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkTerm("wrap16", f16.f_valid, int'(f16.f_out), f16.f_last, idx16(), 65535);
      checkOutput("wrap16_out", int'(f16.f_out), 0);
      checkOutput("wrap16_last", int'(f16.f_last), 0);

      $display("[TB] load Lucas seeds 2/1 during a run");
      f16.f_seed_a = 16'd2;
      f16.f_seed_b = 16'd1;
      applyStimulus(1'b1, 1'b1, 1'b1);
      checkOutput("load_valid", int'(f16.f_valid), 0);
      modelReset(2, 1);
      for (int i = 0; i < 24; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         if (i < 6) checkOutput("lucas_head", int'(f16.f_out), lucasHead[i]);
         checkTerm("lucas", f16.f_valid, int'(f16.f_out), f16.f_last, idx16(), 65535);
      end
      checkOutput("lucas_top_out", int'(f16.f_out), 64079);
      checkOutput("lucas_top_last", int'(f16.f_last), 1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkTerm("lucas_wrap", f16.f_valid, int'(f16.f_out), f16.f_last, idx16(), 65535);
      checkOutput("lucas_wrap_out", int'(f16.f_out), 2);

      $display("[TB] 8-bit run to 233 and wrap");
      doReset();
      modelReset(0, 1);
      f8.f_en    = 1'b1;
      f8.f_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(posedge clock);
         #1;
         checkTerm("run8", f8.f_valid, int'(f8.f_out), f8.f_last, idx8(), 255);
         if (i == 13) begin
            checkOutput("top8_out", int'(f8.f_out), 233);
            checkOutput("top8_last", int'(f8.f_last), 1);
`ifdef FIBO_INDEX_EN
            checkOutput("top8_index", idx8(), 13);
`endif
         end
      end
      checkOutput("wrap8_out", int'(f8.f_out), 0);
      checkOutput("wrap8_last", int'(f8.f_last), 0);
      f8.f_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/fibonacci_gen.md
FIBONACCI_GEN -- requirements
Module: fibonacci_gen

Interface
REQ-001 SHALL have parameter: WIDTH, 16, term width in bits (>=4).
REQ-002 SHALL have parameter: IDX_W, 6, term-index width in bits.
REQ-003 SHALL have port: clock  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port: f_en  in  1  advance enable.
REQ-006 SHALL have port: f_load  in  1  seed load strobe.
REQ-007 SHALL have port: f_seed_a  in  WIDTH  first term to load.
REQ-008 SHALL have port: f_seed_b  in  WIDTH  second term to load.
REQ-009 SHALL have port: f_ready  in  1  downstream accepts f_out.
REQ-010 SHALL have port: f_valid  out  1  f_out holds a term.
REQ-011 SHALL have port: f_out  out  WIDTH  current term.
REQ-012 SHALL have port: f_last  out  1  f_out is the last term representable in WIDTH bits.

Function
REQ-013 SHALL hold registers cur, nxt (WIDTH) and nxt_ovf (1), plus seed registers sa, sb.
REQ-014 SHALL define transfer as f_valid & f_ready at a rising edge.
REQ-015 SHALL define slot_free as !f_valid | f_ready.
REQ-016 SHALL advance when f_en & slot_free & !f_load; otherwise the generator holds.
REQ-017 SHALL, on advance: f_out<=cur, f_last<=nxt_ovf, f_valid<=1, giving 1-cycle latency from f_en to f_valid.
REQ-018 SHALL, on advance with nxt_ovf=0: cur<=nxt; {carry,nxt}<=cur+nxt computed at WIDTH+1 bits; nxt_ovf<=carry.
REQ-019 SHALL, on advance with nxt_ovf=1 (wrap): cur<=sa, nxt<=sb, nxt_ovf<=0.
REQ-020 SHALL, when f_valid & !f_ready, hold f_out, f_last and f_valid stable.
REQ-021 SHALL clear f_valid on a transfer without advance (f_en=0 or f_load=1).
REQ-022 SHALL, on f_load: sa<=f_seed_a, sb<=f_seed_b, cur<=f_seed_a, nxt<=f_seed_b, nxt_ovf<=0, f_valid<=0. Load has priority over advance.
REQ-023 SHALL complete a pending transfer when it coincides with f_load; the term is consumed and then flushed, never duplicated.
REQ-024 SHALL produce, with seeds 0/1 and WIDTH=16: 0,1,1,2,3,5,...,46368 (f_last=1), then 0,1,...
REQ-025 SHALL apply no ordering constraint to seeds; arbitrary seeds (e.g. Lucas 2/1) follow REQ-018/019.

Reset
REQ-026 SHALL, while reset=1, force: f_valid=0, f_out=0, f_last=0, cur=0, nxt=1, nxt_ovf=0, sa=0, sb=1, f_index=0 (if present), independent of clock.
REQ-027 SHALL, on reset asserted mid-sequence or mid-stall, discard all state; the first term after release is 0.

Configuration
REQ-028 SHALL, when macro FIBO_INDEX_EN is defined, add port f_index  out  IDX_W  index of the term on f_out.
REQ-029 SHALL, with FIBO_INDEX_EN, keep an internal counter: reset/load -> 0; each advance presents it, then increments; a wrap resets it to 0; it wraps modulo 2^IDX_W.
REQ-030 SHALL, without FIBO_INDEX_EN, omit the f_index port and counter logic entirely; all other behaviour is identical.

Verification
REQ-031 SHALL cover: reset, f_en=1, f_ready=1 -> f_out 0,1,1,2,3,5,8 on consecutive cycles, f_valid rising 1 cycle after f_en.
REQ-032 SHALL cover: continuous run, WIDTH=16 -> 46368 with f_last=1 (f_index=24), next term 0 with f_last=0 (f_index=0).
REQ-033 SHALL cover: f_ready=0 for 3 cycles while f_out=5 -> f_out/f_valid held at 5; after f_ready=1 -> 8 follows, with no skipped or repeated term.
REQ-034 SHALL cover: f_load with seeds 2/1 during a run -> f_valid=0 next cycle, then 2,1,3,4,7,11; wrap returns to 2.
REQ-035 SHALL cover: WIDTH=8 run -> last term 233 with f_last=1 (f_index=13), then 0.
REQ-036 SHALL cover: reset pulse mid-stall with f_out=13 -> immediate f_valid=0, f_out=0; after release -> sequence restarts at 0.
